// File: rtl/fighter_pkg.sv
// Shared types and constants for the fighter attack logic.
// Phase encodings, coordinate width and saturating helpers.
package fighter_pkg;

  typedef enum logic [1:0] {
    PH_IDLE     = 2'd0,
    PH_STARTUP  = 2'd1,
    PH_ACTIVE   = 2'd2,
    PH_RECOVERY = 2'd3
  } phase_e;

  localparam int COORD_W = 10;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam logic [COORD_W-1:0] COORD_MAX = '1;

  localparam int ATK_ID_0 = 0;
  localparam int ATK_ID_1 = 1;
  localparam int ATK_ID_2 = 2;
  localparam int ATK_ID_3 = 3;

  function automatic logic [COORD_W-1:0] sat_add(
    input logic [COORD_W-1:0] a,
    input logic [COORD_W-1:0] b
  );
    logic [COORD_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[COORD_W] ? COORD_MAX : s[COORD_W-1:0];
  endfunction

  function automatic logic [COORD_W-1:0] sat_sub(
    input logic [COORD_W-1:0] a,
    input logic [COORD_W-1:0] b
  );
    return (a >= b) ? a - b : '0;
  endfunction

endpackage

// File: rtl/atk_req_latch.sv
// Attack request edge capture, pending vector and priority pick.
// Edges seen in the same clk as scen are held for the next frame.
module atk_req_latch
  import fighter_pkg::*;
#(
  parameter int NUM_ATK = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               scen,
  input  logic               enable,
  input  logic [NUM_ATK-1:0] req,
  output logic               win_valid,
  output logic [ID_W-1:0]    win_id
);

  logic [NUM_ATK-1:0] prev;
  logic [NUM_ATK-1:0] pend;
  logic [NUM_ATK-1:0] edges;

  assign edges = req & ~prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev <= '0;
      pend <= '0;
    end else begin
      prev <= req;
      if (!enable)
        pend <= '0;
      else if (scen)
        pend <= edges;
      else
        pend <= pend | edges;
    end
  end

  always_comb begin
    win_valid = |pend;
    win_id    = '0;
    for (int i = NUM_ATK - 1; i >= 0; i--)
      if (pend[i])
        win_id = ID_W'(i);
  end

endmodule

// File: rtl/attack_sequencer.sv
// Multi-channel attack phase sequencer with one-deep chain buffer,
// facing-aware hitbox and once-per-attack hit pulse.
module attack_sequencer
  import fighter_pkg::*;
#(
  parameter int NUM_ATK = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 6,
  parameter logic [NUM_ATK*CNT_W-1:0] STARTUP_F  = {4{6'd4}},
  parameter logic [NUM_ATK*CNT_W-1:0] ACTIVE_F   = {4{6'd3}},
  parameter logic [NUM_ATK*CNT_W-1:0] RECOVERY_F = {4{6'd8}},
  parameter logic [NUM_ATK*10-1:0]    HB_W       = {4{10'd30}},
  parameter logic [NUM_ATK*10-1:0]    HB_H       = {4{10'd60}},
  parameter int BODY_W     = 60,
  parameter int BUF_WINDOW = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               scen,
  input  logic               attack_enable,
  input  logic [NUM_ATK-1:0] attack_req,
  input  logic [9:0]         pos_x,
  input  logic [9:0]         pos_y,
  input  logic               facing_right,
  input  logic               hit_detect,
  output logic               attack_busy,
  output logic               attack_active,
  output logic [ID_W-1:0]    attack_id,
  output logic [1:0]         phase,
  output logic [9:0]         hb_x0,
  output logic [9:0]         hb_x1,
  output logic [9:0]         hb_y0,
  output logic [9:0]         hb_y1,
  output logic               hit_pulse
);

  localparam logic [CNT_W-1:0]   WIN  = CNT_W'(BUF_WINDOW);
  localparam logic [COORD_W-1:0] BODY = COORD_W'(BODY_W);

  // A zero frame count behaves like one frame.
  function automatic logic [CNT_W-1:0] load(
    input logic [NUM_ATK*CNT_W-1:0] f,
    input logic [ID_W-1:0]          i
  );
    logic [CNT_W-1:0] v;
    v = f[int'(i)*CNT_W +: CNT_W];
    return (v == '0) ? '0 : v - CNT_W'(1);
  endfunction

  phase_e           ph, ph_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [ID_W-1:0]  id, id_n;
  logic             buf_v, buf_v_n;
  logic [ID_W-1:0]  buf_id, buf_id_n;
  logic             hit_done, hd_n;
  logic             hit_q, hit_n;

  logic             win_valid;
  logic [ID_W-1:0]  win_id;
  logic             win_ok, in_win, take;
  logic             mrg_v;
  logic [ID_W-1:0]  mrg_id;

  atk_req_latch #(
    .NUM_ATK (NUM_ATK),
    .ID_W    (ID_W)
  ) u_latch (
    .clk       (clk),
    .reset_n   (reset_n),
    .scen      (scen),
    .enable    (attack_enable),
    .req       (attack_req),
    .win_valid (win_valid),
    .win_id    (win_id)
  );

  assign win_ok = win_valid & attack_enable;
  assign in_win = (ph == PH_RECOVERY) && (cnt < WIN);
  assign take   = win_ok && in_win
               && (!buf_v || win_id < buf_id);
  assign mrg_v  = buf_v | take;
  assign mrg_id = take ? win_id : buf_id;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ph       <= PH_IDLE;
      cnt      <= '0;
      id       <= '0;
      buf_v    <= 1'b0;
      buf_id   <= '0;
      hit_done <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      ph       <= ph_n;
      cnt      <= cnt_n;
      id       <= id_n;
      buf_v    <= buf_v_n;
      buf_id   <= buf_id_n;
      hit_done <= hd_n;
      hit_q    <= hit_n;
    end
  end

  always_comb begin
    ph_n     = ph;
    cnt_n    = cnt;
    id_n     = id;
    buf_v_n  = buf_v;
    buf_id_n = buf_id;
    hd_n     = hit_done;
    hit_n    = 1'b0;
    if (ph == PH_ACTIVE && hit_detect && !hit_done) begin
      hit_n = 1'b1;
      hd_n  = 1'b1;
    end
    if (scen) begin
      unique case (ph)
        PH_IDLE: begin
          if (win_ok) begin
            ph_n  = PH_STARTUP;
            id_n  = win_id;
            cnt_n = load(STARTUP_F, win_id);
            hd_n  = 1'b0;
          end
        end
        PH_STARTUP: begin
          if (cnt == '0) begin
            ph_n  = PH_ACTIVE;
            cnt_n = load(ACTIVE_F, id);
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end
        PH_ACTIVE: begin
          if (cnt == '0) begin
            ph_n  = PH_RECOVERY;
            cnt_n = load(RECOVERY_F, id);
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end
        PH_RECOVERY: begin
          buf_v_n  = mrg_v;
          buf_id_n = mrg_id;
          if (cnt != '0) begin
            cnt_n = cnt - CNT_W'(1);
          end else if (mrg_v && attack_enable) begin
            // chain straight into the buffered attack
            ph_n    = PH_STARTUP;
            id_n    = mrg_id;
            cnt_n   = load(STARTUP_F, mrg_id);
            hd_n    = 1'b0;
            buf_v_n = 1'b0;
          end else begin
            ph_n    = PH_IDLE;
            buf_v_n = 1'b0;
          end
        end
        default: ;
      endcase
    end
    if (!attack_enable)
      buf_v_n = 1'b0;
  end

  logic [COORD_W-1:0] w, h;
  logic [COORD_W-1:0] x0_d, x1_d;
  logic [COORD_W-1:0] x0_q, x1_q, y0_q, y1_q;

  assign w = HB_W[int'(id)*COORD_W +: COORD_W];
  assign h = HB_H[int'(id)*COORD_W +: COORD_W];

  always_comb begin
    x0_d = '0;
    x1_d = '0;
    unique case (1'b1)
      facing_right: begin
        x0_d = sat_add(pos_x, BODY);
        x1_d = sat_add(x0_d, w);
      end
      default: begin
        x0_d = sat_sub(pos_x, w);
        x1_d = pos_x;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x0_q <= '0;
      x1_q <= '0;
      y0_q <= '0;
      y1_q <= '0;
    end else begin
      x0_q <= x0_d;
      x1_q <= x1_d;
      y0_q <= pos_y;
      y1_q <= sat_add(pos_y, h);
    end
  end

  assign hb_x0 = (ph == PH_IDLE) ? '0 : x0_q;
  assign hb_x1 = (ph == PH_IDLE) ? '0 : x1_q;
  assign hb_y0 = (ph == PH_IDLE) ? '0 : y0_q;
  assign hb_y1 = (ph == PH_IDLE) ? '0 : y1_q;

  assign attack_busy   = (ph != PH_IDLE);
  assign attack_active = (ph == PH_ACTIVE);
  assign attack_id     = id;
  assign phase         = ph;
  assign hit_pulse     = hit_q;

endmodule

// File: doc/attack_sequencer.md
Name: attack_sequencer

Overview:
Parametrised successor to the fixed two-attack player attack block. Supports NUM_ATK attack channels, each with its own startup/active/recovery frame timing and hitbox size, plus a one-entry input buffer for chaining attacks. It generates a facing-aware hitbox rectangle and a once-per-attack hit pulse. It sits between the button/switch inputs and the renderer and collision logic, and runs on the pixel clock with the per-frame SCEN tick.

Parameters:
NUM_ATK, 4, number of attack channels; index 0 has the highest priority
ID_W, 2, width of attack_id; must satisfy 2**ID_W >= NUM_ATK
CNT_W, 6, width of the frame counter
STARTUP_F, {4{6'd4}}, packed NUM_ATK*CNT_W; startup frames per attack
ACTIVE_F, {4{6'd3}}, packed NUM_ATK*CNT_W; active (hitbox live) frames per attack
RECOVERY_F, {4{6'd8}}, packed NUM_ATK*CNT_W; recovery frames per attack
HB_W, {4{10'd30}}, packed NUM_ATK*10; hitbox width per attack
HB_H, {4{10'd60}}, packed NUM_ATK*10; hitbox height per attack
BODY_W, 60, player box width
BUF_WINDOW, 4, number of final recovery frames during which a request is buffered

Ports:
clk  in  1  pixel clock
reset_n  in  1  asynchronous, active-low reset
scen  in  1  one-cycle frame tick
attack_enable  in  1  permits new attacks to start
attack_req  in  NUM_ATK  level request per attack channel
pos_x  in  10  player left x
pos_y  in  10  player top y
facing_right  in  1  player facing direction
hit_detect  in  1  collision of the hitbox with the opponent
attack_busy  out  1  high in any phase other than IDLE
attack_active  out  1  high in the ACTIVE phase
attack_id  out  ID_W  current attack index
phase  out  2  current phase: IDLE=0, STARTUP=1, ACTIVE=2, RECOVERY=3
hb_x0, hb_x1  out  10  hitbox x range [x0, x1)
hb_y0, hb_y1  out  10  hitbox y range [y0, y1)
hit_pulse  out  1  one-clock pulse on the first hit of each attack

Behaviour:
- Reset (async, reset_n=0): phase IDLE, counter 0, buffer empty, pending 0, all outputs 0.
- Request capture: attack_req is rising-edge detected every clk (registered previous value). Detected edges are OR-ed into a pending vector. Pending is consumed and cleared on scen.
- Arbitration: the lowest set index wins; other pending bits are discarded.
- FSM transitions happen only on scen. The counter loads (frames-1) on phase entry and decrements on each scen. When the counter is 0, the phase advances on that scen.
- A frame parameter of 0 is treated as 1.
- IDLE -> STARTUP: scen with a pending winner and attack_enable=1. Latch attack_id at this point.
- STARTUP -> ACTIVE -> RECOVERY follow the counter rule.
- RECOVERY exit, buffer valid and attack_enable=1: go directly to STARTUP of the buffered id. No IDLE frame is inserted.
- RECOVERY exit, buffer empty: go to IDLE.
- Buffer:
  - A winner consumed during RECOVERY while counter < BUF_WINDOW is stored in the buffer.
  - A later winner replaces the stored one only if its index is lower.
  - Winners consumed in STARTUP, ACTIVE, or early RECOVERY are dropped.
- attack_enable=0: no new starts; the in-flight attack completes normally; the buffer and pending vector are cleared.
- Hit: hit_detect=1 while phase==ACTIVE and hit_done=0 -> hit_pulse=1 for exactly one clk, and hit_done is set. hit_done clears on STARTUP entry. hit_detect is ignored in all other phases.
- Hitbox: registered, updated every clk from the current pos and facing, with w and h taken from the current id.
  - Facing right: x0 = pos_x+BODY_W, x1 = x0+w.
  - Facing left: x1 = pos_x, x0 = pos_x-w, saturating at 0.
  - All sums use 11-bit arithmetic and saturate at 1023.
  - y0 = pos_y, y1 = pos_y+h (saturating).
  - All hitbox outputs are 0 when phase==IDLE.
- Latency: the first ACTIVE frame begins STARTUP_F scen ticks after the start scen. The phase output changes on the clk after scen.
- A scen pulse and a req edge in the same clk: the edge is captured for the next scen, not the current one.

Decomposition:
- fighter_pkg holds:
  - Phase encodings (PH_IDLE, PH_STARTUP, PH_ACTIVE, PH_RECOVERY)
  - COORD_W=10
  - Screen limits
  - Attack id constants
- One sub-module: atk_req_latch, which performs edge detection, maintains the pending vector, and does priority arbitration. Its outputs are win_valid and win_id.

Test Plan:
1. Reset, then attack_req[1] pulse, with STARTUP=4, ACTIVE=3, RECOVERY=8 -> phase 1 for 4 scen, 2 for 3 scen, 3 for 8 scen, then 0. attack_id=1 throughout.
2. Facing right, pos_x=100, pos_y=300, id 0 (w=30, h=60), ACTIVE -> hb=(160,190,300,360). Facing left with pos_x=10 -> hb_x0=0 (saturated), hb_x1=10.
3. Request id 2 in the 3rd-to-last recovery frame, then id 1 in the last recovery frame -> STARTUP of id 1 follows RECOVERY directly; phase never returns to 0.
4. Request id 3 during ACTIVE -> dropped; phase reaches IDLE after recovery.
5. hit_detect held high for the entire ACTIVE phase -> exactly one hit_pulse. hit_detect during STARTUP -> no pulse.
6. reset_n low mid-ACTIVE -> all outputs 0 immediately (async). attack_enable=0 with the buffer loaded -> no chained attack; phase returns to IDLE.
